// File: rtl/bw_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bw_seq_pkg
//  Purpose  : Shared types and constants for the black/white frame sequencer:
//             frame geometry defaults, luma width, threshold constants and
//             the sequencer state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package bw_seq_pkg;

    localparam int FRAME_W_DEF = 640;   // pixels per line
    localparam int FRAME_H_DEF = 480;   // lines per frame
    localparam int LUMA_W      = 11;    // weighted R+G+B sum width
    localparam int THR_RESET   = 600;   // threshold after reset
    localparam int THR_MIN     = 64;    // auto-threshold lower clamp
    localparam int THR_MAX     = 960;   // auto-threshold upper clamp
    localparam int X_W         = 10;
    localparam int Y_W         = 9;

    typedef logic [LUMA_W-1:0] luma_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bw_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bw_frame_sequencer_if
//  Purpose  : SDRAM read-port link between the frame reader and the
//             sequencer.
//  Signals  : read_request  sequencer -> reader, 1-cycle frame read pulse
//             pix_valid     reader -> sequencer, one pixel per high cycle
//             luma          reader -> sequencer, luma of current pixel
//  Modports : master = SDRAM reader side, slave = sequencer side
//  Revision : 1.0  initial release
// ============================================================================
interface bw_frame_sequencer_if;
    import bw_seq_pkg::*;

    logic  read_request;
    logic  pix_valid;
    luma_t luma;

    modport master (
        output pix_valid,
        output luma,
        input  read_request
    );

    modport slave (
        input  pix_valid,
        input  luma,
        output read_request
    );

endinterface
`default_nettype wire

// File: rtl/bw_frame_sequencer_auto_threshold.sv
`default_nettype none
// ============================================================================
//  Module   : bw_auto_threshold
//  Purpose  : Per-frame mean-luma estimator. Sums the luma of pixels on a
//             16x16 grid (x[3:0]==0 and y[3:0]==0) until 1024 samples are
//             taken; at frame end the mean (sum>>10) clamped to
//             [THR_MIN, THR_MAX] becomes the threshold for the next frame.
//             Only built when AUTO_THRESHOLD_EN is defined.
//  Ports    : i_clk, i_rst_n        clock, sync active-low reset
//             i_clear               frame start, clears the accumulator
//             i_sample              pixel accepted this cycle
//             i_x_lo, i_y_lo        low nibbles of the pixel coordinates
//             i_luma                luma of the accepted pixel
//             i_frame_done          accepted pixel is the last of the frame
//             o_thr_next            threshold to load at next frame start
//  Revision : 1.0  initial release
// ============================================================================
`ifdef AUTO_THRESHOLD_EN
module bw_auto_threshold
    import bw_seq_pkg::*;
(
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    input  wire logic       i_clear,
    input  wire logic       i_sample,
    input  wire logic [3:0] i_x_lo,
    input  wire logic [3:0] i_y_lo,
    input  wire luma_t      i_luma,
    input  wire logic       i_frame_done,
    output luma_t           o_thr_next
);

    localparam luma_t C_THR_MIN   = luma_t'(THR_MIN);
    localparam luma_t C_THR_MAX   = luma_t'(THR_MAX);
    localparam luma_t C_THR_RESET = luma_t'(THR_RESET);

    logic [20:0] r_sum;
    logic [10:0] r_cnt;
    luma_t       r_thr_next;

    logic        w_take;
    logic [20:0] w_sum_nxt;
    luma_t       w_mean;
    luma_t       w_clamped;

    // r_cnt[10] set means 1024 samples already taken
    assign w_take    = i_sample && (i_x_lo == 4'd0) && (i_y_lo == 4'd0) && !r_cnt[10];
    // Include the current sample so the estimate is correct even if the last
    // pixel of the frame happens to sit on the sampling grid.
    assign w_sum_nxt = r_sum + (w_take ? {10'd0, i_luma} : 21'd0);
    assign w_mean    = w_sum_nxt[20:10];
    assign w_clamped = (w_mean < C_THR_MIN) ? C_THR_MIN :
                       (w_mean > C_THR_MAX) ? C_THR_MAX : w_mean;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sum      <= '0;
            r_cnt      <= '0;
            r_thr_next <= C_THR_RESET;
        end else if (i_clear) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else begin
            r_sum <= w_sum_nxt;
            if (w_take) begin
                r_cnt <= r_cnt + 11'd1;
            end
            if (i_frame_done) begin
                r_thr_next <= w_clamped;
            end
        end
    end

    assign o_thr_next = r_thr_next;

endmodule
`endif
`default_nettype wire

// File: rtl/bw_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bw_frame_sequencer
//  Purpose  : Frame-level controller for the grayscale/threshold pixel path.
//             On i_start requests a frame from the SDRAM reader, counts the
//             streamed pixels into x/y, thresholds each luma (dark = luma <=
//             threshold) and flags frame end and the first-frame VGA start.
//  Config   : AUTO_THRESHOLD_EN - threshold derived from the previous frame's
//             mean luma instead of i_threshold.
//  Ports    : i_clk, i_rst_n   clock, synchronous active-low reset
//             i_start          level, frame request while high
//             i_threshold      static threshold, sampled at frame start
//             io_sdram         SDRAM read port (slave side)
//             o_vga_start      1-cycle pulse with first read request
//             o_valid/o_bw     registered pixel valid / 1 = dark
//             o_x/o_y          coordinates of the o_valid pixel
//             o_frame_done     1-cycle pulse with last pixel of frame
//             o_threshold      threshold applied to current frame
//  Revision : 1.0  initial release
// ============================================================================
module bw_frame_sequencer
    import bw_seq_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_start,
    input  wire luma_t            i_threshold,
    bw_frame_sequencer_if.slave   io_sdram,
    output logic                  o_vga_start,
    output logic                  o_valid,
    output logic                  o_bw,
    output logic [X_W-1:0]        o_x,
    output logic [Y_W-1:0]        o_y,
    output logic                  o_frame_done,
    output luma_t                 o_threshold
);

    localparam logic [X_W-1:0] C_X_LAST    = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0] C_Y_LAST    = Y_W'(FRAME_H - 1);
    localparam luma_t          C_THR_RESET = luma_t'(THR_RESET);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_first;
    logic [X_W-1:0]  r_x;
    logic [Y_W-1:0]  r_y;
    logic            r_read_request;
    logic            r_vga_start;
    logic            r_valid;
    logic            r_bw;
    logic [X_W-1:0]  r_out_x;
    logic [Y_W-1:0]  r_out_y;
    logic            r_frame_done;
    luma_t           r_thr;

    logic            w_frame_start;
    logic            w_accept;
    logic            w_last_pix;
    luma_t           w_thr_next;

    assign w_last_pix = (r_x == C_X_LAST) && (r_y == C_Y_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (io_sdram.pix_valid) begin
                    w_accept = 1'b1;
                    if (w_last_pix) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // one frame per i_start high period
                if (!i_start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------- threshold
`ifdef AUTO_THRESHOLD_EN
    luma_t w_auto_thr;

    bw_auto_threshold u_auto_threshold (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_frame_start),
        .i_sample     (w_accept),
        .i_x_lo       (r_x[3:0]),
        .i_y_lo       (r_y[3:0]),
        .i_luma       (io_sdram.luma),
        .i_frame_done (w_accept && w_last_pix),
        .o_thr_next   (w_auto_thr)
    );

    assign w_thr_next = w_auto_thr;
`else
    assign w_thr_next = i_threshold;
`endif

    // ----------------------------------------------------------- datapath
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_first        <= 1'b1;
            r_x            <= '0;
            r_y            <= '0;
            r_read_request <= 1'b0;
            r_vga_start    <= 1'b0;
            r_valid        <= 1'b0;
            r_bw           <= 1'b0;
            r_out_x        <= '0;
            r_out_y        <= '0;
            r_frame_done   <= 1'b0;
            r_thr          <= C_THR_RESET;
        end else begin
            r_read_request <= w_frame_start;
            r_vga_start    <= w_frame_start && r_first;
            r_valid        <= w_accept;
            r_frame_done   <= w_accept && w_last_pix;

            if (w_frame_start) begin
                r_x   <= '0;
                r_y   <= '0;
                r_thr <= w_thr_next;
            end

            if (w_accept) begin
                r_out_x <= r_x;
                r_out_y <= r_y;
                r_bw    <= !(io_sdram.luma > r_thr);
                if (r_x == C_X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
                if (w_last_pix) begin
                    r_first <= 1'b0;
                end
            end
        end
    end

    assign io_sdram.read_request = r_read_request;
    assign o_vga_start           = r_vga_start;
    assign o_valid               = r_valid;
    assign o_bw                  = r_bw;
    assign o_x                   = r_out_x;
    assign o_y                   = r_out_y;
    assign o_frame_done          = r_frame_done;
    assign o_threshold           = r_thr;

endmodule
`default_nettype wire
